// File: rtl/uart_config_tx.sv
// uart_config_tx: 8N1 UART transmitter fed by a byte FIFO; optional even parity bit with UART_TX_PARITY_EN.
// Latency: start bit is driven one cycle after the accepting edge when idle; queued frames follow with no idle gap.
// Backpressure: ready_o is low while the FIFO holds FIFO_DEPTH bytes; a same-cycle pop frees space one cycle later.

module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    output logic                     push_rdy,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   level,
    output logic [$clog2(DEPTH):0]   level_nxt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop_ok;

    assign push      = push_vld && push_rdy;
    assign pop_ok    = pop && (level != '0);
    assign level_nxt = level + LW'(push) - LW'(pop_ok);
    assign pop_dat   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            push_rdy <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level    <= level_nxt;
            push_rdy <= (level_nxt != LW'(DEPTH));
        end
    end
endmodule

module uart_config_tx #(
    parameter int CLK_FREQ   = 12500000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          Tx,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          TransmitLED
);
    localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                      state;
    logic [CW-1:0]               cnt;
    logic [7:0]                  shreg;
    logic [2:0]                  idx;
    logic [7:0]                  pop_dat;
    logic [$clog2(FIFO_DEPTH):0] level_nxt;
    logic                        bit_end;
    logic                        frame_done;
    logic                        pop;
    logic                        nxt_idle;
`ifdef UART_TX_PARITY_EN
    logic                        par;
`endif

    fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_vld  (valid_i),
        .push_rdy  (ready_o),
        .push_dat  (data_i),
        .pop       (pop),
        .pop_dat   (pop_dat),
        .level     (fifo_level_o),
        .level_nxt (level_nxt)
    );

    assign bit_end    = (cnt == '0);
    assign frame_done = (state == IDLE) || ((state == STOP) && bit_end);
    // A finishing stop bit pops the next byte directly, giving gapless frames.
    assign pop        = frame_done && (fifo_level_o != '0);
    assign nxt_idle   = frame_done && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            idx         <= '0;
            Tx          <= 1'b1;
            busy_o      <= 1'b0;
            TransmitLED <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            busy_o      <= !nxt_idle || (level_nxt != '0);
            TransmitLED <= !nxt_idle;
            if (pop) begin
                state <= START;
                cnt   <= BIT_LAST;
                shreg <= pop_dat;
                Tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                par   <= ^pop_dat;
`endif
            end else if (state == IDLE) begin
                Tx  <= 1'b1;
                cnt <= '0;
            end else if (!bit_end) begin
                cnt <= cnt - CW'(1);
            end else begin
                cnt <= BIT_LAST;
                case (state)
                    START: begin
                        state <= DATA;
                        Tx    <= shreg[0];
                        shreg <= {1'b0, shreg[7:1]};
                        idx   <= '0;
                    end
                    DATA: begin
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            Tx    <= par;
`else
                            state <= STOP;
                            Tx    <= 1'b1;
`endif
                        end else begin
                            Tx    <= shreg[0];
                            shreg <= {1'b0, shreg[7:1]};
                            idx   <= idx + 3'd1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state <= STOP;
                        Tx    <= 1'b1;
                    end
`endif
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        Tx    <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_config_tx.sv
// Randomized bench for uart_config_tx: a behavioural line decoder checks bytes, order, timing and reset abort.
`timescale 1ns/1ps
module tb_uart_config_tx;
    localparam int CLK_FREQ   = 1000000;
    localparam int BAUD_RATE  = 250000;
    localparam int FIFO_DEPTH = 16;
    localparam int CPB        = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       valid_i = 1'b0;
    logic [7:0] data_i  = 8'h00;
    logic       ready_o;
    logic       Tx;
    logic       busy_o;
    logic [4:0] fifo_level_o;
    logic       TransmitLED;

    uart_config_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .Tx           (Tx),
        .busy_o       (busy_o),
        .fifo_level_o (fifo_level_o),
        .TransmitLED  (TransmitLED)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    byte unsigned rxq[$];
    byte unsigned expq[$];
    int           startq[$];
`ifdef UART_TX_PARITY_EN
    bit           parq[$];
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        rxq.delete();
        expq.delete();
        startq.delete();
`ifdef UART_TX_PARITY_EN
        parq.delete();
`endif
    endtask

    // Caller sits on a negedge with ready_o high; returns on the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] d, output int hs);
        data_i  = d;
        valid_i = 1'b1;
        expq.push_back(d);
        @(posedge clk);
        @(negedge clk);
        hs      = cyc;
        valid_i = 1'b0;
        data_i  = 8'($urandom);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy_o, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, rxq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
            check(tag, rxq[i], expq[i]);
        end
    endtask

    // Line decoder: samples each bit in its middle, like a host UART would.
    initial begin : line_monitor
        logic [7:0] b;
        int         t;
        forever begin
            @(negedge clk);
            if (!reset && Tx === 1'b0) begin
                t = cyc;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = Tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                parq.push_back(Tx);
`endif
                repeat (CPB) @(negedge clk);
                check("stop_bit", Tx, 1);
                rxq.push_back(b);
                startq.push_back(t);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int   hs;
        int   hs2;
        int   bad_tx;
        int   bad_busy;
        int   bad_led;
        int   acc;
        int   guard;
        logic fr[NBITS];
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check("rst_tx", Tx, 1);
        check("rst_ready", ready_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_level", fifo_level_o, 0);
        check("rst_led", TransmitLED, 0);
        reset = 1'b0;

        bad_tx = 0; bad_busy = 0; bad_led = 0;
        repeat (1000) begin
            @(negedge clk);
            if (Tx !== 1'b1) bad_tx++;
            if (busy_o !== 1'b0) bad_busy++;
            if (TransmitLED !== 1'b0) bad_led++;
        end
        check("idle_tx_low_cycles", bad_tx, 0);
        check("idle_busy_cycles", bad_busy, 0);
        check("idle_led_cycles", bad_led, 0);

        // Single 0x55 frame, checked cycle by cycle against its ideal waveform.
        clear_q();
        d = 8'h55;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        fr[9] = 1'($countones(d) % 2);
`endif
        fr[NBITS - 1] = 1'b1;
        push_byte(d, hs);
        check("t1_tx_k0", Tx, 1);
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            check("t1_wave", Tx, fr[(k - 1) / CPB]);
        end
        check("t1_busy_last_stop", busy_o, 1);
        check("t1_led_last_stop", TransmitLED, 1);
        @(negedge clk);
        check("t1_busy_after", busy_o, 0);
        check("t1_led_after", TransmitLED, 0);
        compare_rx("t1_rx");

        // Back-to-back frames.
        clear_q();
        push_byte(8'hA3, hs);
        push_byte(8'h0F, hs2);
        wait_idle("t2_idle", 4 * FRAME);
        compare_rx("t2_rx");
        if (startq.size() == 2) begin
            check("t2_first_start", startq[0] - hs, 1);
            check("t2_gap", startq[1] - startq[0], FRAME);
        end else begin
            check("t2_starts", startq.size(), 2);
        end

`ifdef UART_TX_PARITY_EN
        clear_q();
        push_byte(8'h07, hs);
        push_byte(8'h03, hs2);
        wait_idle("par_idle", 4 * FRAME);
        compare_rx("par_rx");
        check("par_count", parq.size(), 2);
        for (int i = 0; i < parq.size() && i < expq.size(); i++) begin
            check("par_bit", parq[i], $countones(expq[i]) % 2);
        end
        if (startq.size() == 2) check("par_frame_len", startq[1] - startq[0], 11 * CPB);
`endif

        // Fill the FIFO while a frame is in flight.
        clear_q();
        push_byte(8'($urandom), hs);
        @(negedge clk);
        acc = 0; guard = 0;
        valid_i = 1'b1;
        data_i  = 8'($urandom);
        while (ready_o && guard < 100) begin
            expq.push_back(data_i);
            acc++;
            @(negedge clk);
            data_i = 8'($urandom);
            guard++;
        end
        check("fill_accepted", acc, FIFO_DEPTH);
        check("fill_level", fifo_level_o, FIFO_DEPTH);
        check("fill_ready", ready_o, 0);
        @(negedge clk);
        check("fill_ready_held", ready_o, 0);
        valid_i = 1'b0;
        wait_idle("fill_idle", 20 * FRAME);
        compare_rx("fill_rx");

        // Reset during data bit 3 of 0xFF with five bytes queued.
        clear_q();
        push_byte(8'hFF, hs);
        repeat (5) push_byte(8'($urandom), hs2);
        while (cyc - hs < 17) @(negedge clk);
        check("rst_mid_level_before", fifo_level_o, 5);
        check("rst_mid_tx_before", Tx, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_tx", Tx, 1);
        check("rst_mid_level", fifo_level_o, 0);
        check("rst_mid_ready", ready_o, 1);
        check("rst_mid_busy", busy_o, 0);
        bad_tx = 0; bad_busy = 0;
        repeat (200) begin
            @(negedge clk);
            if (Tx !== 1'b1) bad_tx++;
            if (busy_o !== 1'b0) bad_busy++;
        end
        check("rst_mid_no_frames", bad_tx, 0);
        check("rst_mid_no_busy", bad_busy, 0);

        // Random traffic with backpressure.
        clear_q();
        repeat (300) begin
            valid_i = ($urandom_range(0, 3) == 0);
            data_i  = 8'($urandom);
            if (valid_i && ready_o) expq.push_back(data_i);
            @(negedge clk);
        end
        valid_i = 1'b0;
        wait_idle("rand_idle", 30 * FRAME);
        compare_rx("rand_rx");
        for (int i = 1; i < startq.size(); i++) begin
            if (startq[i] - startq[i - 1] < FRAME) check("rand_spacing", startq[i] - startq[i - 1], FRAME);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
